// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch stage with an in-order instruction queue
// Issues word loads at fetch_pc and buffers {pc, inst} pairs for decode.
module if_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        take_jmp,
  input  logic [31:0] jmp_target,
  output logic [1:0]  IF_op,
  output logic [1:0]  IF_len,
  output logic [31:0] IF_addr,
  input  logic        IF_rdy,
  input  logic [31:0] IF_out,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);

  localparam logic [1:0] MEM_NOP  = 2'b00;
  localparam logic [1:0] MEM_LOAD = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [31:0]   fetch_pc;
  logic          rdy_q;

  logic          resp;
  logic          push;
  logic          pop;
  logic          fwd;
  logic [PW-1:0] head_nxt;
  logic [CW-1:0] count_nxt;
  logic [31:0]   pc_nxt;

  assign IF_len = MEM_WORD;

  always_comb begin
    resp      = IF_rdy & ~rdy_q;
    push      = resp & ~take_jmp & (count < FULL);
    pop       = id_valid & id_ready & ~take_jmp;
    head_nxt  = pop ? head + PW'(1) : head;
    pc_nxt    = push ? fetch_pc + 32'd4 : fetch_pc;
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
    // The pushed word becomes the new head when nothing else remains after the pop.
    fwd = push & (count == CW'(pop));
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in && rdy_in && push) begin
      q_pc[tail]   <= fetch_pc;
      q_inst[tail] <= IF_out;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      fetch_pc <= RESET_PC;
      rdy_q    <= 1'b0;
      IF_op    <= MEM_NOP;
      IF_addr  <= RESET_PC;
      id_valid <= 1'b0;
      id_inst  <= 32'h0;
      id_pc    <= 32'h0;
    end else if (rdy_in) begin
      rdy_q <= IF_rdy;
      if (take_jmp) begin
        head     <= '0;
        tail     <= '0;
        count    <= '0;
        fetch_pc <= jmp_target;
        IF_addr  <= jmp_target;
        IF_op    <= MEM_LOAD;
        id_valid <= 1'b0;
      end else begin
        head     <= head_nxt;
        tail     <= push ? tail + PW'(1) : tail;
        count    <= count_nxt;
        fetch_pc <= pc_nxt;
        IF_addr  <= pc_nxt;
        IF_op    <= (count_nxt < FULL) ? MEM_LOAD : MEM_NOP;
        id_valid <= (count_nxt != '0);
        if (count_nxt != '0) begin
          id_pc   <= fwd ? fetch_pc : q_pc[head_nxt];
          id_inst <= fwd ? IF_out : q_inst[head_nxt];
        end
      end
    end
  end

endmodule
